alu_mb_seq: RTL and testbench

- Multi-byte arithmetic sequencer in front of the 8-bit ALU.
- Accepts one request for a 1..MAX_BYTES-byte ADD, SUB, shift-left-by-1 or shift-right-by-1, and drives the ALU one byte per cycle.
- Carries are chained with extra ALU correction passes, because the ALU takes no carry input.
- Assembles the result and returns it with flags over a valid/ready response port. Sits between the execute-stage controller and the ALU's rs/rt/op inputs.

---
 rtl/alu_mb_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_mb_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mb_seq.sv
// alu_mb_seq: multi-byte arithmetic sequencer in front of an 8-bit ALU.
// The block accepts one ADD, SUB, SHL1 or SHR1 request on operands of
// 1..MAX_BYTES bytes. It drives the ALU one byte per cycle. The ALU has no
// carry input, so an incoming carry is folded in with an extra correction
// pass. The assembled result and its flags go out on a valid/ready port.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid_i/req_ready_o     request handshake
//   req_op_i                    00 ADD, 01 SUB, 10 SHL1, 11 SHR1
//   req_len_i                   length in bytes (0 -> 1, >MAX_BYTES -> MAX_BYTES)
//   req_a_i, req_b_i            operands, byte 0 = LSB (B ignored for shifts)
//   alu_rs_o/alu_rt_o/alu_op_o  ALU operands and opcode {OPC,1'b0}; 0 when idle
//   alu_result_i, alu_carry_i   ALU result and carry/borrow/shifted-out bit
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_result_o                result; bytes at or above len are 0
//   rsp_carry_o, rsp_zero_o, rsp_neg_o  final carry and result flags
//   busy_o                      high whenever the FSM is not IDLE
// Optional: when ALU_MB_SEQ_STATS_EN is defined, stat_ops_o counts completed
// responses and stat_fix_o counts correction (PASS2) cycles. Both are 16 bits
// and wrap.
module alu_mb_seq #(
  parameter int         MAX_BYTES = 4,
  parameter int         LEN_W     = 3,
  parameter logic [7:0] OPC_ADD   = 8'h01,
  parameter logic [7:0] OPC_SUB   = 8'h02,
  parameter logic [7:0] OPC_LSL   = 8'h05,
  parameter logic [7:0] OPC_LSR   = 8'h06,
  parameter logic [7:0] OPC_OR    = 8'h04
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [LEN_W-1:0]       req_len_i,
  input  logic [8*MAX_BYTES-1:0] req_a_i,
  input  logic [8*MAX_BYTES-1:0] req_b_i,
  output logic [7:0]             alu_rs_o,
  output logic [7:0]             alu_rt_o,
  output logic [8:0]             alu_op_o,
  input  logic [7:0]             alu_result_i,
  input  logic                   alu_carry_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [8*MAX_BYTES-1:0] rsp_result_o,
  output logic                   rsp_carry_o,
  output logic                   rsp_zero_o,
  output logic                   rsp_neg_o,
`ifdef ALU_MB_SEQ_STATS_EN
  output logic [15:0]            stat_ops_o,
  output logic [15:0]            stat_fix_o,
`endif
  output logic                   busy_o
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SHL = 2'b10, OP_SHR = 2'b11;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;

  state_e                        state_q, state_d;
  logic [MAX_BYTES-1:0][7:0]     a_q, b_q, res_q;
  logic [1:0]                    op_q;
  logic [IDX_W-1:0]              idx_q, end_q, msb_q;
  logic                          cin_q, c1_q;
  logic [7:0]                    r_q;

  logic [LEN_W-1:0] len_c;
  logic [IDX_W-1:0] last_c;
  logic             byte_done, cout, is_shift, is_last;

  // Clamp the length here so the rest of the block only ever sees 1..MAX_BYTES.
  always_comb begin
    len_c = req_len_i;
    if (req_len_i == '0)                        len_c = LEN_W'(1);
    else if (req_len_i > LEN_W'(MAX_BYTES))     len_c = LEN_W'(MAX_BYTES);
  end
  assign last_c = IDX_W'(len_c - LEN_W'(1));

  assign is_shift = op_q[1];
  assign is_last  = (idx_q == end_q);
  // A byte finishes after PASS1 when there is no carry to fold in, or after PASS2.
  assign byte_done = ((state_q == PASS1) && !cin_q) || (state_q == PASS2);
  // For shifts the correction OR never produces a carry, so only the primary
  // pass decides what moves on to the next byte.
  always_comb begin
    cout = alu_carry_i;
    if (state_q == PASS2) cout = is_shift ? c1_q : (c1_q | alu_carry_i);
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    alu_rs_o    = 8'h00;
    alu_rt_o    = 8'h00;
    alu_op_o    = 9'h000;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = PASS1;
      end
      PASS1: begin
        alu_rs_o = a_q[idx_q];
        alu_rt_o = is_shift ? 8'h01 : b_q[idx_q];
        case (op_q)
          OP_ADD:  alu_op_o = {OPC_ADD, 1'b0};
          OP_SUB:  alu_op_o = {OPC_SUB, 1'b0};
          OP_SHL:  alu_op_o = {OPC_LSL, 1'b0};
          default: alu_op_o = {OPC_LSR, 1'b0};
        endcase
        if (cin_q)        state_d = PASS2;
        else if (is_last) state_d = DONE;
      end
      PASS2: begin
        alu_rs_o = r_q;
        case (op_q)
          OP_ADD:  begin alu_rt_o = 8'h01; alu_op_o = {OPC_ADD, 1'b0}; end
          OP_SUB:  begin alu_rt_o = 8'h01; alu_op_o = {OPC_SUB, 1'b0}; end
          OP_SHL:  begin alu_rt_o = 8'h01; alu_op_o = {OPC_OR,  1'b0}; end
          default: begin alu_rt_o = 8'h80; alu_op_o = {OPC_OR,  1'b0}; end
        endcase
        state_d = is_last ? DONE : PASS1;
      end
      default: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_ADD;
      idx_q   <= '0;
      end_q   <= '0;
      msb_q   <= '0;
      cin_q   <= 1'b0;
      c1_q    <= 1'b0;
      r_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        a_q   <= req_a_i;
        b_q   <= req_b_i;
        op_q  <= req_op_i;
        res_q <= '0;
        cin_q <= 1'b0;
        msb_q <= last_c;
        // SHR1 walks from the top byte down so the shifted-out bit feeds lower bytes.
        idx_q <= (req_op_i == OP_SHR) ? last_c : '0;
        end_q <= (req_op_i == OP_SHR) ? '0 : last_c;
      end
      if (state_q == PASS1) begin
        r_q  <= alu_result_i;
        c1_q <= alu_carry_i;
      end
      if (byte_done) begin
        res_q[idx_q] <= alu_result_i;
        cin_q        <= cout;
        idx_q        <= (op_q == OP_SHR) ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
      end
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign rsp_result_o = (state_q == DONE) ? res_q : '0;
  assign rsp_carry_o  = (state_q == DONE) & cin_q;
  // Bytes above len are kept at zero, so the whole register can be tested.
  assign rsp_zero_o   = (state_q == DONE) & (res_q == '0);
  assign rsp_neg_o    = (state_q == DONE) & res_q[msb_q][7];

`ifdef ALU_MB_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_fix_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_q <= 16'h0000;
      stat_fix_q <= 16'h0000;
    end else begin
      if (state_q == DONE && rsp_ready_i) stat_ops_q <= stat_ops_q + 16'h0001;
      if (state_q == PASS2)               stat_fix_q <= stat_fix_q + 16'h0001;
    end
  end
  assign stat_ops_o = stat_ops_q;
  assign stat_fix_o = stat_fix_q;
`endif

endmodule

// File: tb/tb_alu_mb_seq.sv
module tb_alu_mb_seq;
  localparam logic [7:0] T_ADD = 8'h11, T_SUB = 8'h12, T_LSL = 8'h15, T_LSR = 8'h16, T_OR = 8'h14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_op_i;
  logic [2:0]  req_len_i;
  logic [31:0] req_a_i, req_b_i;
  logic [7:0]  alu_rs_o, alu_rt_o, alu_result_i;
  logic [8:0]  alu_op_o;
  logic        alu_carry_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_carry_o, rsp_zero_o, rsp_neg_o, busy_o;
`ifdef ALU_MB_SEQ_STATS_EN
  logic [15:0] stat_ops_o, stat_fix_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [24:0] trace[$];

  always #5 clk = ~clk;

  alu_mb_seq #(.MAX_BYTES(4), .LEN_W(3), .OPC_ADD(T_ADD), .OPC_SUB(T_SUB),
               .OPC_LSL(T_LSL), .OPC_LSR(T_LSR), .OPC_OR(T_OR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_len_i(req_len_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .alu_rs_o(alu_rs_o), .alu_rt_o(alu_rt_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_carry_o(rsp_carry_o), .rsp_zero_o(rsp_zero_o), .rsp_neg_o(rsp_neg_o),
`ifdef ALU_MB_SEQ_STATS_EN
    .stat_ops_o(stat_ops_o), .stat_fix_o(stat_fix_o),
`endif
    .busy_o(busy_o));

  // Behavioural 8-bit ALU
  always_comb begin
    alu_result_i = 8'h00;
    alu_carry_i  = 1'b0;
    case (alu_op_o)
      {T_ADD, 1'b0}: {alu_carry_i, alu_result_i} = {1'b0, alu_rs_o} + {1'b0, alu_rt_o};
      {T_SUB, 1'b0}: begin alu_result_i = alu_rs_o - alu_rt_o; alu_carry_i = (alu_rs_o < alu_rt_o); end
      {T_LSL, 1'b0}: begin alu_result_i = alu_rs_o << 1; alu_carry_i = alu_rs_o[7]; end
      {T_LSR, 1'b0}: begin alu_result_i = alu_rs_o >> 1; alu_carry_i = alu_rs_o[0]; end
      {T_OR,  1'b0}: alu_result_i = alu_rs_o | alu_rt_o;
      default: ;
    endcase
  end

  always @(posedge clk) if (alu_op_o != 9'h000) trace.push_back({alu_rs_o, alu_rt_o, alu_op_o});

  // Drive one request, then count edges after the acceptance edge until rsp_valid (-1 on timeout).
  task automatic issue(input logic [1:0] op, input logic [2:0] len,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    trace.delete();
    req_valid_i = 1'b1; req_op_i = op; req_len_i = len; req_a_i = a; req_b_i = b;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) begin lat = n; break; end
    end
  endtask

  task automatic consume();
    @(negedge clk); rsp_ready_i = 1'b1;
    @(posedge clk); #1 rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_len_i = 3'd0;
    req_a_i = 32'h0; req_b_i = 32'h0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    checks++; if ({alu_rs_o, alu_rt_o, alu_op_o} !== 25'h0) begin errors++; $display("FAIL reset_alu: got %h exp 0", {alu_rs_o, alu_rt_o, alu_op_o}); end
    checks++; if ({rsp_valid_o, rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o} !== 36'h0) begin
      errors++; $display("FAIL reset_rsp: got %h exp 0", {rsp_valid_o, rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o}); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    issue(2'b00, 3'd2, 32'h0000_01FF, 32'h0000_0001, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d exp 3", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o} !== {32'h0000_0200, 3'b000}) begin
      errors++; $display("FAIL add_rsp: got %h/%b%b%b exp 00000200/000", rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o); end
    checks++; if (trace.size() !== 3) begin errors++; $display("FAIL add_passes: got %0d exp 3", trace.size()); end
    else begin
      checks++; if (trace[2] !== {8'h01, 8'h01, T_ADD, 1'b0}) begin errors++; $display("FAIL add_pass2: got %h exp %h", trace[2], {8'h01, 8'h01, T_ADD, 1'b0}); end
    end
    consume();
  endtask

  task automatic test_sub();
    int lat;
    issue(2'b01, 3'd2, 32'h0000_0100, 32'h0000_0001, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sub_latency: got %0d exp 3", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o} !== {32'h0000_00FF, 3'b000}) begin
      errors++; $display("FAIL sub_rsp: got %h/%b%b%b exp 000000ff/000", rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o); end
    consume();
  endtask

  task automatic test_shr();
    int lat;
    issue(2'b11, 3'd3, 32'h0000_0001, 32'hDEAD_BEEF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL shr_latency: got %0d exp 3", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_zero_o} !== {32'h0, 2'b11}) begin
      errors++; $display("FAIL shr_rsp: got %h/%b%b exp 0/11", rsp_result_o, rsp_carry_o, rsp_zero_o); end
    consume();
    issue(2'b11, 3'd3, 32'h0002_0304, 32'h0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL shr2_latency: got %0d exp 4", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o} !== {32'h0001_0182, 3'b000}) begin
      errors++; $display("FAIL shr2_rsp: got %h/%b%b%b exp 00010182/000", rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o); end
    checks++; if (trace.size() !== 4) begin errors++; $display("FAIL shr2_passes: got %0d exp 4", trace.size()); end
    else begin
      checks++; if ({trace[0][24:17], trace[1][24:17], trace[2][24:17]} !== 24'h020304) begin
        errors++; $display("FAIL shr2_order: got %h exp 020304", {trace[0][24:17], trace[1][24:17], trace[2][24:17]}); end
      checks++; if (trace[3] !== {8'h02, 8'h80, T_OR, 1'b0}) begin errors++; $display("FAIL shr2_pass2: got %h exp %h", trace[3], {8'h02, 8'h80, T_OR, 1'b0}); end
    end
    consume();
  endtask

  task automatic test_shl();
    int lat;
    issue(2'b10, 3'd2, 32'h0000_80C0, 32'h0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL shl_latency: got %0d exp 3", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_neg_o} !== {32'h0000_0180, 2'b10}) begin
      errors++; $display("FAIL shl_rsp: got %h/%b%b exp 00000180/10", rsp_result_o, rsp_carry_o, rsp_neg_o); end
    checks++; if (trace.size() !== 3) begin errors++; $display("FAIL shl_passes: got %0d exp 3", trace.size()); end
    else begin
      checks++; if (trace[2] !== {8'h00, 8'h01, T_OR, 1'b0}) begin errors++; $display("FAIL shl_pass2: got %h exp %h", trace[2], {8'h00, 8'h01, T_OR, 1'b0}); end
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b00, 3'd1, 32'hFFFF_FF80, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hold_latency: got %0d exp 1", lat); end
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b00; req_len_i = 3'd1; req_a_i = 32'h1; req_b_i = 32'h2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid_o, req_ready_o, rsp_result_o, rsp_neg_o} !== {2'b10, 32'h0000_0080, 1'b1}) begin
        errors++; $display("FAIL hold_stable%0d: got %b%b %h %b exp 10 00000080 1", i, rsp_valid_o, req_ready_o, rsp_result_o, rsp_neg_o); end
    end
    @(negedge clk) rsp_ready_i = 1'b1;
    @(posedge clk); #1 rsp_ready_i = 1'b0;
    checks++; if ({busy_o, req_ready_o, rsp_valid_o} !== 3'b010) begin
      errors++; $display("FAIL hold_idle: got %b exp 010", {busy_o, req_ready_o, rsp_valid_o}); end
    @(posedge clk); #1 req_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b exp 1", busy_o); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid_o, rsp_result_o} !== {1'b1, 32'h3}) begin
      errors++; $display("FAIL b2b_rsp: got %b %h exp 1 00000003", rsp_valid_o, rsp_result_o); end
    consume();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b00; req_len_i = 3'd4; req_a_i = 32'hFFFF_FFFF; req_b_i = 32'h1;
    @(posedge clk); #1 req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({alu_rs_o, alu_rt_o, alu_op_o} !== {8'hFF, 8'h01, T_ADD, 1'b0}) begin
      errors++; $display("FAIL mid_pass2: got %h exp %h", {alu_rs_o, alu_rt_o, alu_op_o}, {8'hFF, 8'h01, T_ADD, 1'b0}); end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy_o, req_ready_o, rsp_valid_o, alu_rs_o, alu_rt_o, alu_op_o, rsp_result_o} !== {3'b010, 25'h0, 32'h0}) begin
      errors++; $display("FAIL mid_reset: got %b%b%b %h %h exp 010 0 0", busy_o, req_ready_o, rsp_valid_o, {alu_rs_o, alu_rt_o, alu_op_o}, rsp_result_o); end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid_o) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d exp 0", seen); end
  endtask

  task automatic test_len_clamp();
    int lat;
    issue(2'b00, 3'd0, 32'h0000_12F0, 32'h0000_3420, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL len0_latency: got %0d exp 1", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o} !== {32'h0000_0010, 3'b100}) begin
      errors++; $display("FAIL len0_rsp: got %h/%b%b%b exp 00000010/100", rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o); end
    consume();
    issue(2'b00, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL len7_latency: got %0d exp 7", lat); end
    checks++; if ({rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o} !== {32'h0, 3'b110}) begin
      errors++; $display("FAIL len7_rsp: got %h/%b%b%b exp 00000000/110", rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_neg_o); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shr();
    test_shl();
    test_back_to_back();
    test_reset_mid();
    test_len_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
